csr_timer_int_unit: RTL
=======================

Name: csr_timer_int_unit

Overview:
- Parametrised interrupt and timer controller, next generation of the core's interrupt path (hardware interrupt inputs are no longer tied off).
- Owns CSRs ECFG, ESTAT.IS, TID, TCFG, TVAL and TICLR, plus the stable counter.
- Produces has_int toward the WB/ID exception logic.
- Instantiated beside csr_reg in mycpu_top. csr_reg forwards hits on the owned CSR numbers to this unit.

Parameters:
- NUM_HW_INT, 8: hardware interrupt lines; supported range 1..8; mapped to IS[2+NUM_HW_INT-1:2]; unused IS bits read 0.
- TIMER_W, 32: TVAL/TCFG.InitVal width incl. 2 low zero bits; 8..32.
- CNT_W, 64: stable counter width; 32..64.
- SYNC_STAGES, 2: synchroniser depth on hw_int_in/ipi_int_in; 0 = bypass.
- COREID, 0: TID reset value.

Ports:
- clk  in  1  core clock
- resetn  in  1  synchronous, active-low reset
- csr_we  in  1  CSR write strobe (WB stage, already qualified by valid)
- csr_num  in  14  CSR address for read and write
- csr_wmask  in  32  bitwise write mask
- csr_wvalue  in  32  write data
- csr_rvalue  out  32  combinational read data for owned CSRs; 0 otherwise
- csr_hit  out  1  csr_num selects an owned CSR
- crmd_ie  in  1  CRMD.IE from csr_reg
- hw_int_in  in  NUM_HW_INT  asynchronous level hardware interrupts
- ipi_int_in  in  1  asynchronous level inter-processor interrupt
- has_int  out  1  enabled interrupt pending
- cnt_value  out  CNT_W  stable counter, for rdcntvl/rdcntvh
- tid_value  out  32  TID, for rdcntid

Behaviour:
- Clocking/reset: one clock; reset synchronous, active-low, on resetn.
- Reset values:
  - TCFG.En=0; TVAL=all-ones; LIE=0; IS=0; counter=0; TID=COREID; synchroniser flops=0.
  - Reset outputs follow: has_int=0, csr_rvalue=0 unless an owned CSR is addressed.
- CSR map (writes are masked: new = (old & ~wmask) | (wvalue & wmask)):
  - ECFG 0x04: LIE[12:0]; bit10 reads 0; upper bits read 0.
  - ESTAT 0x05: only IS[1:0] (software interrupts) are writable; IS[12:2] are read-only here.
  - TID 0x40: fully writable.
  - TCFG 0x41: En[0], Periodic[1], InitVal[TIMER_W-1:2].
  - TVAL 0x42: read-only.
  - TICLR 0x44: writing 1 to bit0 clears IS[11]; always reads 0.
- Interrupt sources:
  - IS[2+k] = synchronised hw_int_in[k]. Level-sensitive; updated every cycle; latency SYNC_STAGES cycles.
  - IS[12] = synchronised ipi_int_in.
- Timer (TVAL), evaluated in priority order each cycle:
  1. TCFG write with resulting En=1: TVAL <= {InitVal,2'b00} next cycle; no fire that cycle.
  2. Else if En=1 and TVAL!=0: TVAL decrements by 1.
  3. Else if En=1 and TVAL==0: IS[11] <= 1 (fire).
     - Periodic=1: TVAL reloads {InitVal,2'b00}.
     - Periodic=0: TVAL <= all-ones and the timer goes dormant. Dormant means no further decrement and no fire until TCFG is rewritten; En bit unchanged.
  4. En=0: TVAL holds.
- Timer period: InitVal = N gives a fire every 4N+1 cycles in periodic mode.
- TI set/clear collision: if a fire and a TICLR bit0 write occur in the same cycle, set wins and IS[11]=1.
- has_int = crmd_ie & |(IS[12:0] & LIE[12:0]). Combinational from registers; no extra latency.
- Stable counter: increments every cycle; wraps from all-ones to 0; not writable.
- Write/read ordering: a write to an owned CSR is visible on csr_rvalue the cycle after csr_we.
- Non-owned csr_num: writes are ignored.
- Reset mid-count: all timer state returns to its reset values; a pending TI is lost.

Decomposition:
- Shared package csr_pkg holds:
  - CSR number constants (ECFG, ESTAT, TID, TCFG, TVAL, TICLR).
  - IS bit indices (SWI0/1, HWI base, TI=11, IPI=12).
  - TCFG field positions and LIE valid mask 13'h1BFF.
- One sub-module: int_sync.
  - SYNC_STAGES-deep flop chain, width NUM_HW_INT+1.
  - Synchronous active-low reset to 0.
  - Generate-bypass when SYNC_STAGES=0.

Test Plan:
- Periodic timer:
  - Stimulus: write TCFG=0x0000000B (InitVal=2, periodic, En); LIE=0x800; crmd_ie=1.
  - Response: TVAL reads 8, then counts down to 0. IS[11] sets 9 cycles after the write and has_int=1.
  - Then write TICLR=1: IS[11]=0 the next cycle, and it re-fires 9 cycles after the previous fire.
- One-shot timer:
  - Stimulus: TCFG=0x00000009 (InitVal=2, one-shot, En).
  - Response: single fire; TVAL=0xFFFFFFFF afterwards.
  - After TICLR, IS[11] stays 0 for 100 cycles.
- Collision:
  - Stimulus: TICLR bit0 write issued in the exact fire cycle.
  - Response: IS[11]=1 afterwards.
- Hardware interrupt path (NUM_HW_INT=8, SYNC_STAGES=2):
  - Stimulus: assert hw_int_in[3].
  - Response: IS[5]=1 after 2 cycles.
  - With LIE=0x020: has_int=1 iff crmd_ie=1.
  - Deassert the input: IS[5] clears 2 cycles later.
- Masked writes:
  - ESTAT write wvalue=0xFFFFFFFF, wmask=0x3: only IS[1:0] set.
  - ECFG write 0xFFFF: reads back 0x1BFF.
  - TVAL write: ignored.
- Counter and reset:
  - Run the counter to 1000.
  - Pulse resetn=0 for 1 cycle mid timer count.
  - Response: cnt_value=0, TVAL=0xFFFFFFFF, IS=0, has_int=0, TID=COREID the following cycle.

Source files
------------

// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared constants, types and helpers for the CSR timer/interrupt unit
package csr_pkg;

  // Owned CSR numbers
  localparam logic [13:0] CSR_ECFG  = 14'h04;
  localparam logic [13:0] CSR_ESTAT = 14'h05;
  localparam logic [13:0] CSR_TID   = 14'h40;
  localparam logic [13:0] CSR_TCFG  = 14'h41;
  localparam logic [13:0] CSR_TVAL  = 14'h42;
  localparam logic [13:0] CSR_TICLR = 14'h44;

  // ESTAT.IS bit indices
  localparam int IS_SWI0     = 0;
  localparam int IS_SWI1     = 1;
  localparam int IS_HWI_BASE = 2;
  localparam int IS_TI       = 11;
  localparam int IS_IPI      = 12;

  // TCFG field positions
  localparam int TCFG_EN          = 0;
  localparam int TCFG_PERIODIC    = 1;
  localparam int TCFG_INITVAL_LSB = 2;

  // Implemented LIE bits; bit 10 has no source behind it
  localparam logic [12:0] LIE_MASK = 13'h1BFF;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_ECFG,
    SEL_ESTAT,
    SEL_TID,
    SEL_TCFG,
    SEL_TVAL,
    SEL_TICLR
  } csr_sel_e;

  // Dormant: counting stopped until TCFG is rewritten with En=1
  typedef enum logic {
    TMR_DORMANT,
    TMR_ARMED
  } tmr_state_e;

  function automatic csr_sel_e csr_decode(input logic [13:0] num);
    case (num)
      CSR_ECFG:  return SEL_ECFG;
      CSR_ESTAT: return SEL_ESTAT;
      CSR_TID:   return SEL_TID;
      CSR_TCFG:  return SEL_TCFG;
      CSR_TVAL:  return SEL_TVAL;
      CSR_TICLR: return SEL_TICLR;
      default:   return SEL_NONE;
    endcase
  endfunction

  function automatic logic [31:0] masked_write(input logic [31:0] old_v,
                                               input logic [31:0] wmask,
                                               input logic [31:0] wvalue);
    return (old_v & ~wmask) | (wvalue & wmask);
  endfunction

endpackage

// File: rtl/csr_timer_int_unit_if.sv
// rtl/csr_timer_int_unit_if.sv - CSR access bus between csr_reg and the timer/interrupt unit
interface csr_timer_int_unit_if;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic [31:0] csr_rvalue;
  logic        csr_hit;

  modport master (
    output csr_we, csr_num, csr_wmask, csr_wvalue,
    input  csr_rvalue, csr_hit
  );

  modport slave (
    input  csr_we, csr_num, csr_wmask, csr_wvalue,
    output csr_rvalue, csr_hit
  );
endinterface

// File: rtl/int_sync.sv
// rtl/int_sync.sv - reset-to-zero flop chain synchroniser with zero-depth bypass
module int_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign q_o = d_i;
    end else begin : g_chain
      logic [W-1:0] sync_q [STAGES];

      // Shift the asynchronous levels through STAGES flops
      always_ff @(posedge clk) begin
        if (!resetn) begin
          for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= d_i;
          for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end

      assign q_o = sync_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/csr_timer_int_unit.sv
// rtl/csr_timer_int_unit.sv - ECFG/ESTAT.IS/TID/TCFG/TVAL/TICLR, stable counter and has_int
module csr_timer_int_unit
  import csr_pkg::*;
#(
  parameter int          NUM_HW_INT  = 8,
  parameter int          TIMER_W     = 32,
  parameter int          CNT_W       = 64,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] COREID      = 32'h0
) (
  input  logic                  clk,
  input  logic                  resetn,
  csr_timer_int_unit_if.slave   csr,
  input  logic                  crmd_ie,
  input  logic [NUM_HW_INT-1:0] hw_int_in,
  input  logic                  ipi_int_in,
  output logic                  has_int,
  output logic [CNT_W-1:0]      cnt_value,
  output logic [31:0]           tid_value
);

  csr_sel_e sel;
  logic     wr_ecfg, wr_estat, wr_tid, wr_tcfg, wr_ticlr;

  logic [12:0]         lie_q, lie_d;
  logic [1:0]          swi_q, swi_d;
  logic                ti_q, ti_d;
  logic [31:0]         tid_q, tid_d;
  logic [TIMER_W-1:0]  tcfg_q, tcfg_d;
  logic [TIMER_W-1:0]  tval_q, tval_d;
  tmr_state_e          tmr_q, tmr_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                fire;

  logic [NUM_HW_INT:0] sync_out;
  logic [12:0]         is_w;
  logic [TIMER_W-1:0]  reload_new, reload_cur;

  assign sel      = csr_decode(csr.csr_num);
  assign wr_ecfg  = csr.csr_we && (sel == SEL_ECFG);
  assign wr_estat = csr.csr_we && (sel == SEL_ESTAT);
  assign wr_tid   = csr.csr_we && (sel == SEL_TID);
  assign wr_tcfg  = csr.csr_we && (sel == SEL_TCFG);
  assign wr_ticlr = csr.csr_we && (sel == SEL_TICLR);

  // IPI rides in the top bit of the shared synchroniser
  int_sync #(.W(NUM_HW_INT + 1), .STAGES(SYNC_STAGES)) u_int_sync (
    .clk    (clk),
    .resetn (resetn),
    .d_i    ({ipi_int_in, hw_int_in}),
    .q_o    (sync_out)
  );

  // Assemble ESTAT.IS; unused hardware lines and bit 10 read zero
  always_comb begin
    is_w                               = '0;
    is_w[IS_SWI1:IS_SWI0]              = swi_q;
    is_w[IS_HWI_BASE +: NUM_HW_INT]    = sync_out[NUM_HW_INT-1:0];
    is_w[IS_TI]                        = ti_q;
    is_w[IS_IPI]                       = sync_out[NUM_HW_INT];
  end

  assign reload_new = {tcfg_d[TIMER_W-1:TCFG_INITVAL_LSB], 2'b00};
  assign reload_cur = {tcfg_q[TIMER_W-1:TCFG_INITVAL_LSB], 2'b00};

  // Next state of the software-visible CSRs
  always_comb begin
    lie_d  = lie_q;
    swi_d  = swi_q;
    tid_d  = tid_q;
    tcfg_d = tcfg_q;
    if (wr_ecfg)
      lie_d = (lie_q & ~csr.csr_wmask[12:0] | csr.csr_wvalue[12:0] & csr.csr_wmask[12:0]) & LIE_MASK;
    if (wr_estat)
      swi_d = (swi_q & ~csr.csr_wmask[1:0]) | (csr.csr_wvalue[1:0] & csr.csr_wmask[1:0]);
    if (wr_tid)
      tid_d = masked_write(tid_q, csr.csr_wmask, csr.csr_wvalue);
    if (wr_tcfg)
      tcfg_d = (tcfg_q & ~csr.csr_wmask[TIMER_W-1:0])
             | (csr.csr_wvalue[TIMER_W-1:0] & csr.csr_wmask[TIMER_W-1:0]);
  end

  // Timer FSM: load on enabling TCFG write, else count down, fire at zero
  always_comb begin
    tmr_d  = tmr_q;
    tval_d = tval_q;
    fire   = 1'b0;
    if (wr_tcfg && tcfg_d[TCFG_EN]) begin
      tval_d = reload_new;
      tmr_d  = TMR_ARMED;
    end else if (tcfg_q[TCFG_EN] && (tmr_q == TMR_ARMED)) begin
      if (tval_q != '0) begin
        tval_d = tval_q - 1'b1;
      end else begin
        fire = 1'b1;
        if (tcfg_q[TCFG_PERIODIC]) begin
          tval_d = reload_cur;
        end else begin
          tval_d = '1;
          tmr_d  = TMR_DORMANT;
        end
      end
    end
  end

  // A fire in the same cycle as a TICLR clear leaves TI set
  always_comb begin
    ti_d = ti_q;
    if (fire)
      ti_d = 1'b1;
    else if (wr_ticlr && csr.csr_wmask[0] && csr.csr_wvalue[0])
      ti_d = 1'b0;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lie_q  <= '0;
      swi_q  <= '0;
      ti_q   <= 1'b0;
      tid_q  <= COREID;
      tcfg_q <= '0;
      tval_q <= '1;
      tmr_q  <= TMR_DORMANT;
      cnt_q  <= '0;
    end else begin
      lie_q  <= lie_d;
      swi_q  <= swi_d;
      ti_q   <= ti_d;
      tid_q  <= tid_d;
      tcfg_q <= tcfg_d;
      tval_q <= tval_d;
      tmr_q  <= tmr_d;
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  // Combinational read mux for owned CSRs
  always_comb begin
    csr.csr_rvalue = '0;
    csr.csr_hit    = (sel != SEL_NONE);
    case (sel)
      SEL_ECFG:  csr.csr_rvalue[12:0]        = lie_q;
      SEL_ESTAT: csr.csr_rvalue[12:0]        = is_w;
      SEL_TID:   csr.csr_rvalue              = tid_q;
      SEL_TCFG:  csr.csr_rvalue[TIMER_W-1:0] = tcfg_q;
      SEL_TVAL:  csr.csr_rvalue[TIMER_W-1:0] = tval_q;
      default:   csr.csr_rvalue              = '0;
    endcase
  end

  assign has_int   = crmd_ie & |(is_w & lie_q);
  assign cnt_value = cnt_q;
  assign tid_value = tid_q;

endmodule
